times_table_sequencer: RTL and testbench
========================================

Name: times_table_sequencer

Overview:
- Upstream driver and result collector for the times-table multiplier.
- Walks operand pairs (a, b) and pulses the multiplier's enable once per pair.
- Captures each registered product one cycle later, accumulates a running sum, and flags any product that differs from a*b.
- Runs either a single table (a fixed, b = 0..7) or the full 8x8 table.

Parameters:
- OP_W, 3, operand width of a and b.
- RES_W, 6, width of the product returned by the multiplier.
- SUM_W, 10, accumulator width; full-table sum is 784.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled in IDLE only.
- mode  in  1  0 = single table, 1 = full table.
- table_sel  in  OP_W  fixed multiplicand a when mode=0.
- hold  in  1  stall request; sampled in ISSUE.
- result_in  in  RES_W  product from the multiplier.
- a  out  OP_W  operand a to the multiplier.
- b  out  OP_W  operand b to the multiplier.
- enable  out  1  multiplier enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle run-complete pulse.
- sum  out  SUM_W  running sum of captured products.
- mismatch  out  1  sticky product-error flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; a=0, b=0, sum=0, done=0, mismatch=0.
  - enable=0, busy=0.
  - Reset mid-run aborts immediately; no partial completion and no done pulse.
- States: IDLE, ISSUE, CAPTURE, DONE. All registers update on the rising clk edge.
- IDLE:
  - On start=1: a <= (mode ? 0 : table_sel); b <= 0; sum <= 0; mismatch <= 0; latch mode internally; go to ISSUE.
  - start=0: stay in IDLE.
- ISSUE:
  - enable = ~hold (combinational from state and hold).
  - hold=1: stay in ISSUE, a and b unchanged.
  - hold=0: go to CAPTURE.
- CAPTURE:
  - enable=0.
  - result_in holds the product of the pair issued in the previous cycle (multiplier has 1-cycle latency).
  - sum <= sum + result_in, zero-extended.
  - If result_in != a*b (computed at RES_W bits): mismatch <= 1. It stays set until the next accepted start or reset.
  - Advance:
    - b != 7: b++, go to ISSUE.
    - b == 7 and latched mode=1 and a != 7: a++, b <= 0, go to ISSUE.
    - Otherwise: go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - a, b, sum and mismatch keep their final values until the next start.
- Timing with hold=0:
  - Each pair takes 2 cycles.
  - Single table: done is high in the 17th cycle after the start edge.
  - Full table: done is high in the 129th cycle after the start edge.
- Simultaneous events:
  - start while busy is ignored.
  - hold has no effect outside ISSUE.
  - mode and table_sel are used only at start acceptance; later changes do not affect the run.
- Widths:
  - a*b is at most 49 and fits RES_W.
  - sum never exceeds 784 and fits SUM_W; no overflow handling is required.
  - a and b never wrap past 7 within a run.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, ISSUE, CAPTURE, DONE.
  - constants OP_MAX=7, TABLE_SIZE=8.
  - RES_W, SUM_W.
- One sub-module, operand_counter: a 2-digit (a, b) counter with load, step, and a last-pair output. The FSM and accumulator stay in the top module.
- The bench instantiates times_table_sequencer with the existing multiply block in the loop.

Test Plan:
- Single table, mode=0, table_sel=5, start pulsed, hold=0:
  - 8 enable pulses on alternating cycles, b = 0..7.
  - done in cycle 17; sum=140; mismatch=0.
- Full table, mode=1, start pulsed:
  - 64 enable pulses; done in cycle 129; sum=784; final a=7, b=7; mismatch=0.
- Hold stall, mode=0, table_sel=3, hold=1 for 4 cycles while at b=2:
  - enable=0 during the stall; a=3, b=2 held.
  - done is delayed 4 cycles to cycle 21; sum=84.
- Fault injection, bench forces result_in to 0 on pair (2,3), mode=0, table_sel=2:
  - mismatch rises in that CAPTURE cycle and stays high; sum=50; done still pulses.
  - Next accepted start clears mismatch.
- Reset mid-run, rst_n=0 asynchronously during a full-table run at a=4:
  - All outputs go to 0 immediately, without waiting for a clock edge; no done pulse.
  - After rst_n=1, a new start gives a correct run.
- start held high through a whole single-table run:
  - Extra start is ignored while busy.
  - The run restarts in the cycle after DONE, and sum re-clears to 0 at that start.

Source files
------------

// File: rtl/times_table_sequencer_pkg.sv
// Shared definitions for the times-table sequencer.
// Holds the sequencer state encoding, the operand range constants
// and the default result/accumulator widths used by the top and
// the operand counter.
package times_table_sequencer_pkg;

    // Largest operand value and number of entries in one table.
    localparam int OP_MAX     = 7;
    localparam int TABLE_SIZE = 8;

    // Product width returned by the multiplier and accumulator width.
    // The full 8x8 table sums to 784, which fits 10 bits.
    localparam int RES_W = 6;
    localparam int SUM_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/times_table_sequencer_operand_counter.sv
// Two-digit (a, b) operand counter for the times-table sequencer.
// b is the fast digit; a advances only when multi_table is set and
// b has reached its maximum. Neither digit ever wraps within a run.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         load a <= load_a, b <= 0 (takes priority over step)
//   load_a       starting multiplicand
//   step         advance to the next pair
//   multi_table  1 = walk all tables (a advances), 0 = single table
//   a, b         current operand pair
//   last_pair    the current pair is the final pair of the run
module operand_counter #(
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [OP_W-1:0] load_a,
    input  logic            step,
    input  logic            multi_table,
    output logic [OP_W-1:0] a,
    output logic [OP_W-1:0] b,
    output logic            last_pair
);
    import times_table_sequencer_pkg::*;

    localparam logic [OP_W-1:0] DIGIT_MAX = OP_W'(OP_MAX);

    logic [OP_W-1:0] a_reg;
    logic [OP_W-1:0] a_next;
    logic [OP_W-1:0] b_reg;
    logic [OP_W-1:0] b_next;
    logic            a_at_max;
    logic            b_at_max;

    assign a_at_max  = (a_reg == DIGIT_MAX);
    assign b_at_max  = (b_reg == DIGIT_MAX);
    assign last_pair = b_at_max && (!multi_table || a_at_max);

    always_comb begin
        a_next = a_reg;
        b_next = b_reg;
        if (load) begin
            a_next = load_a;
            b_next = '0;
        end else if (step) begin
            if (!b_at_max) begin
                b_next = b_reg + OP_W'(1);
            end else if (multi_table && !a_at_max) begin
                a_next = a_reg + OP_W'(1);
                b_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            a_reg <= a_next;
            b_reg <= b_next;
        end
    end

    assign a = a_reg;
    assign b = b_reg;

endmodule

// File: rtl/times_table_sequencer.sv
// Upstream driver and result collector for the times-table multiplier.
// Walks operand pairs, pulses enable once per pair, captures each
// product one cycle later, accumulates the sum and flags any product
// that differs from a*b.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        begin a run (only honoured in IDLE)
//   mode         0 = single table (a = table_sel), 1 = full 8x8 table
//   table_sel    multiplicand for single-table runs
//   hold         stall request, only acts while issuing
//   result_in    product returned by the multiplier (1-cycle latency)
//   a, b         operands to the multiplier
//   enable       multiplier enable
//   busy         high whenever not IDLE
//   done         one-cycle run-complete pulse
//   sum          running sum of captured products
//   mismatch     sticky flag: some product differed from a*b
module times_table_sequencer #(
    parameter int OP_W  = 3,
    parameter int RES_W = times_table_sequencer_pkg::RES_W,
    parameter int SUM_W = times_table_sequencer_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [OP_W-1:0]  table_sel,
    input  logic             hold,
    input  logic [RES_W-1:0] result_in,
    output logic [OP_W-1:0]  a,
    output logic [OP_W-1:0]  b,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             mismatch
);
    import times_table_sequencer_pkg::*;

    state_t           state_reg;
    state_t           state_next;
    logic             mode_reg;
    logic             load;
    logic             step;
    logic             capture;
    logic             last_pair;
    logic [OP_W-1:0]  load_a;
    logic [SUM_W-1:0] sum_reg;
    logic             mismatch_reg;
    logic [RES_W-1:0] expected_product;

    assign load_a = mode ? '0 : table_sel;

    operand_counter #(
        .OP_W (OP_W)
    ) u_operand_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_a      (load_a),
        .step        (step),
        .multi_table (mode_reg),
        .a           (a),
        .b           (b),
        .last_pair   (last_pair)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                mode_reg <= mode;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        enable     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                enable = ~hold;
                if (!hold) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                // On the final pair the operands stay put so the last
                // pair remains visible after the run.
                step       = ~last_pair;
                state_next = last_pair ? DONE : ISSUE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // a and b still hold the pair whose product arrives in CAPTURE;
    // they only advance on the edge that ends CAPTURE.
    assign expected_product = {{(RES_W-OP_W){1'b0}}, a} * {{(RES_W-OP_W){1'b0}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg      <= '0;
            mismatch_reg <= 1'b0;
        end else if (load) begin
            sum_reg      <= '0;
            mismatch_reg <= 1'b0;
        end else if (capture) begin
            sum_reg <= sum_reg + {{(SUM_W-RES_W){1'b0}}, result_in};
            if (result_in != expected_product) begin
                mismatch_reg <= 1'b1;
            end
        end
    end

    assign sum      = sum_reg;
    assign mismatch = mismatch_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_times_table_sequencer.sv
// Testbench for times_table_sequencer with a 1-cycle registered
// multiplier model in the loop.
module tb_times_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] table_sel = 3'd0;
    logic       hold = 1'b0;
    logic [5:0] result_in;
    logic [2:0] a;
    logic [2:0] b;
    logic       enable;
    logic       busy;
    logic       done;
    logic [9:0] sum;
    logic       mismatch;

    int checks = 0;
    int errors = 0;
    bit inject_fault = 1'b0;

    typedef struct {
        bit         m;
        logic [2:0] sel;
        int         hold_b;
        int         hold_len;
        bit         inj;
        int         exp_sum;
        int         exp_done;
        int         exp_a;
        int         exp_b;
        int         exp_mm;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    times_table_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .table_sel (table_sel),
        .hold      (hold),
        .result_in (result_in),
        .a         (a),
        .b         (b),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .mismatch  (mismatch)
    );

    // Multiplier in the loop: registered product, optional fault on (2,3).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_in <= 6'd0;
        end else if (enable) begin
            if (inject_fault && a == 3'd2 && b == 3'd3) begin
                result_in <= 6'd0;
            end else begin
                result_in <= {3'b000, a} * {3'b000, b};
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One run. The reference is a list of pairs with their products;
    // pair k may issue once it is eligible and hold is low, the next
    // pair becomes eligible two cycles after an issue, and done follows
    // two cycles after the last issue. Cycle 1 is the cycle after the
    // start edge.
    task automatic run_table(input bit m, input logic [2:0] sel,
                             input int hold_b, input int hold_len,
                             input bit rand_hold, input bit keep_start,
                             input bit inj,
                             output int got_sum, output int got_done_cyc,
                             output int got_a, output int got_b, output int got_mm);
        int qa[$];
        int qb[$];
        int prod[$];
        int issue_cyc[$];
        int n;
        int idx;
        int next_elig;
        int last_issue;
        int stalls;
        int exp_sum;
        int exp_mm;
        int total;
        bit exp_en;
        bit exp_done;
        bit finished;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                if (m || x == int'(sel)) begin
                    qa.push_back(x);
                    qb.push_back(y);
                    prod.push_back((inj && x == 2 && y == 3) ? 0 : x * y);
                end
            end
        end
        n = qa.size();
        total = 0;
        for (int k = 0; k < n; k++) total += prod[k];
        inject_fault = inj;
        @(negedge clk);
        mode = m;
        table_sel = sel;
        hold = 1'b0;
        start = 1'b1;
        idx = 0;
        next_elig = 1;
        last_issue = -10;
        stalls = 0;
        finished = 1'b0;
        got_done_cyc = -1;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge clk);
            start = keep_start;
            mode = 1'($urandom);
            table_sel = 3'($urandom);
            if (rand_hold) begin
                hold = ($urandom_range(0, 2) == 0);
            end else begin
                hold = (idx < n && cyc >= next_elig && qb[idx] == hold_b && stalls < hold_len);
            end
            if (hold && idx < n && cyc >= next_elig) stalls++;
            #1;
            exp_sum = 0;
            exp_mm = 0;
            for (int k = 0; k < issue_cyc.size(); k++) begin
                if (issue_cyc[k] <= cyc - 2) begin
                    exp_sum += prod[k];
                    if (prod[k] != qa[k] * qb[k]) exp_mm = 1;
                end
            end
            exp_en = (idx < n && cyc >= next_elig && !hold);
            exp_done = (idx == n && cyc == last_issue + 2);
            chk("enable", int'(enable), int'(exp_en));
            chk("done", int'(done), int'(exp_done));
            chk("busy", int'(busy), 1);
            chk("running_sum", int'(sum), exp_sum);
            chk("running_mismatch", int'(mismatch), exp_mm);
            if (exp_en) begin
                chk("issue_a", int'(a), qa[idx]);
                chk("issue_b", int'(b), qb[idx]);
                issue_cyc.push_back(cyc);
                last_issue = cyc;
                next_elig = cyc + 2;
                idx++;
            end
            if (done) got_done_cyc = cyc;
            if (done || exp_done) finished = 1'b1;
        end
        if (!finished) chk("run_timeout", 0, 1);
        hold = 1'b0;
        got_sum = int'(sum);
        got_a = int'(a);
        got_b = int'(b);
        got_mm = int'(mismatch);
        chk("model_sum", got_sum, total);
        chk("model_final_a", got_a, qa[n-1]);
        chk("model_final_b", got_b, qb[n-1]);
        if (!keep_start) begin
            @(negedge clk);
            #1;
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_sum_kept", int'(sum), total);
            chk("idle_mismatch_kept", int'(mismatch), int'(inj && (m || sel == 3'd2)));
        end
    endtask

    initial begin
        int r_sum;
        int r_done;
        int r_a;
        int r_b;
        int r_mm;
        bit seen;
        bit rm;
        logic [2:0] rs;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // m, sel, hold_b, hold_len, inj, sum, done cycle, a, b, mismatch
        vecs[0] = '{1'b0, 3'd5, -1, 0, 1'b0, 140, 17, 5, 7, 0};
        vecs[1] = '{1'b1, 3'd0, -1, 0, 1'b0, 784, 129, 7, 7, 0};
        vecs[2] = '{1'b0, 3'd3, 2, 4, 1'b0, 84, 21, 3, 7, 0};
        vecs[3] = '{1'b0, 3'd2, -1, 0, 1'b1, 50, 17, 2, 7, 1};
        vecs[4] = '{1'b0, 3'd0, -1, 0, 1'b0, 0, 17, 0, 7, 0};
        vecs[5] = '{1'b0, 3'd7, -1, 0, 1'b0, 196, 17, 7, 7, 0};

        for (int i = 0; i < 6; i++) begin
            run_table(vecs[i].m, vecs[i].sel, vecs[i].hold_b, vecs[i].hold_len,
                      1'b0, 1'b0, vecs[i].inj, r_sum, r_done, r_a, r_b, r_mm);
            chk("vec_sum", r_sum, vecs[i].exp_sum);
            chk("vec_done_cycle", r_done, vecs[i].exp_done);
            chk("vec_a", r_a, vecs[i].exp_a);
            chk("vec_b", r_b, vecs[i].exp_b);
            chk("vec_mismatch", r_mm, vecs[i].exp_mm);
            $display("vec %0d: mode=%0d sel=%0d hold_len=%0d inj=%0d sum=%0d done_cycle=%0d a=%0d b=%0d mismatch=%0d",
                     i, vecs[i].m, vecs[i].sel, vecs[i].hold_len, vecs[i].inj,
                     r_sum, r_done, r_a, r_b, r_mm);
        end

        // Randomized runs with random hold activity in every state.
        for (int i = 0; i < 6; i++) begin
            rm = ($urandom_range(0, 3) == 0);
            rs = 3'($urandom);
            run_table(rm, rs, -1, 0, 1'b1, 1'b0, 1'b0, r_sum, r_done, r_a, r_b, r_mm);
            $display("rand %0d: mode=%0d sel=%0d sum=%0d done_cycle=%0d mismatch=%0d",
                     i, rm, rs, r_sum, r_done, r_mm);
        end

        // start held high through a whole single-table run.
        run_table(1'b0, 3'd6, -1, 0, 1'b0, 1'b1, 1'b0, r_sum, r_done, r_a, r_b, r_mm);
        chk("hs_done_cycle", r_done, 17);
        mode = 1'b0;
        table_sel = 3'd1;
        @(negedge clk);
        #1;
        chk("hs_idle_busy", int'(busy), 0);
        chk("hs_idle_sum", int'(sum), 168);
        @(negedge clk);
        #1;
        chk("hs_restart_busy", int'(busy), 1);
        chk("hs_restart_sum", int'(sum), 0);
        chk("hs_restart_a", int'(a), 1);
        chk("hs_restart_b", int'(b), 0);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("hs_second_done", int'(seen), 1);
        chk("hs_second_sum", int'(sum), 28);
        $display("held-start: restart sum=%0d done_seen=%0d", sum, seen);

        // Asynchronous reset in the middle of a full-table run.
        @(negedge clk);
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (a == 3'd4) seen = 1'b1;
        end
        chk("mr_reached_a4", int'(seen), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_a", int'(a), 0);
        chk("mr_b", int'(b), 0);
        chk("mr_sum", int'(sum), 0);
        chk("mr_enable", int'(enable), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_mismatch", int'(mismatch), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mr_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        $display("mid-run reset: outputs cleared");
        run_table(1'b0, 3'd4, -1, 0, 1'b0, 1'b0, 1'b0, r_sum, r_done, r_a, r_b, r_mm);
        chk("mr_after_sum", r_sum, 112);
        chk("mr_after_done_cycle", r_done, 17);
        $display("post-reset run: sum=%0d done_cycle=%0d", r_sum, r_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
